// File: rtl/bsu_pkg.sv
// bsu_pkg: shift mode encodings shared by the barrel shift unit
package bsu_pkg;
  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_t;
endpackage

// File: rtl/bsu_shift_core.sv
// bsu_shift_core: combinational log2(DATA_W)-level barrel shifter with carry
module bsu_shift_core
  import bsu_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  mode_t              mode,
  output logic [DATA_W-1:0]  result,
  output logic               carry
);
  logic left, rol, fill;
  // One extra slot beside the data catches the last bit shifted out.
  logic [DATA_W:0] st [SHAMT_W+1];
  assign left  = mode == MODE_LSL || mode == MODE_ROL;
  assign rol   = mode == MODE_ROL;
  assign fill  = mode == MODE_ASR && data[DATA_W-1];
  assign st[0] = left ? {1'b0, data} : {data, 1'b0};
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
    localparam int amt = 1 << k;
    logic [DATA_W:0] l, r;
    assign l = {st[k][DATA_W-amt:0], rol ? st[k][DATA_W-1:DATA_W-amt] : {amt{1'b0}}};
    assign r = {{amt{fill}}, st[k][DATA_W:amt]};
    assign st[k+1] = shamt[k] ? (left ? l : r) : st[k];
  end
  assign result = left ? st[SHAMT_W][DATA_W-1:0] : st[SHAMT_W][DATA_W:1];
  assign carry  = shamt == '0 ? 1'b0 :
                  rol         ? result[0] :
                  left        ? st[SHAMT_W][DATA_W] : st[SHAMT_W][0];
endmodule

// File: rtl/barrel_shift_unit.sv
// barrel_shift_unit: two-stage valid/ready pipeline around a barrel shifter
module barrel_shift_unit
  import bsu_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_carry,
  output logic               out_zero
);
  logic v1, v2, adv1, adv2, c;
  logic [DATA_W-1:0] d1, res;
  logic [SHAMT_W-1:0] n1;
  mode_t m1;
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1 && !rst;
  assign out_valid = v2;
  bsu_shift_core #(.DATA_W(DATA_W)) u_core (
    .data  (d1),
    .shamt (n1),
    .mode  (m1),
    .result(res),
    .carry (c)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv1 && in_valid) begin
        d1 <= in_data;
        n1 <= in_shamt;
        m1 <= mode_t'(in_mode);
      end
      if (adv2) v2 <= v1;
      if (adv2 && v1) begin
        out_data  <= res;
        out_carry <= c;
        out_zero  <= res == '0;
      end
    end
  end
endmodule

// File: doc/barrel_shift_unit.md
BARREL_SHIFT_UNIT -- requirements
Module: barrel_shift_unit

Interface
REQ-001 Parameter DATA_W, default 8, data width; SHALL be a power of two, 4..64.
REQ-002 Derived constant SHAMT_W = clog2(DATA_W), shift-amount width; not overridable.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit accepts a request this cycle.
REQ-007 in_data  input  DATA_W  operand.
REQ-008 in_shamt  input  SHAMT_W  shift amount, 0..DATA_W-1.
REQ-009 in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out_data  output  DATA_W  shifted result.
REQ-013 out_carry  output  1  last bit shifted out; 0 when shamt = 0.
REQ-014 out_zero  output  1  out_data equals all zeros.

Function
REQ-015 Transfer SHALL occur on an input or output port only on a cycle where valid and ready are both 1.
REQ-016 Pipeline SHALL have two register stages: S1 (captured request) and S2 (registered result); the shift logic sits between S1 and S2.
REQ-017 Stage advance: adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1, combinational, with no dependency on in_valid.
REQ-018 Latency: a request accepted at edge k SHALL appear with out_valid = 1 after edge k+2 when not stalled.
REQ-019 Throughput SHALL be one result per cycle while out_ready stays 1.
REQ-020 With out_ready = 0, S2 SHALL hold; S1 SHALL fill; in_ready SHALL drop once both stages are full; no request lost or duplicated.
REQ-021 out_data, out_carry and out_zero SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-022 LSL: zero fill; carry = in_data[DATA_W-n] for n > 0.
REQ-023 LSR: zero fill; carry = in_data[n-1] for n > 0.
REQ-024 ASR: fill with in_data[DATA_W-1]; carry = in_data[n-1] for n > 0.
REQ-025 ROL: rotate left by n; carry = result[0] for n > 0.
REQ-026 shamt = 0 in any mode: out_data = in_data, out_carry = 0.
REQ-027 Simultaneous accept at the input and drain at the output in one cycle SHALL be handled without a bubble.

Reset
REQ-028 On rst = 1 at a clock edge: v1 = v2 = 0, out_valid = 0, out_data = 0, out_carry = 0, out_zero = 0.
REQ-029 During reset, in_ready SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all in-flight requests; the first request after reset deasserts SHALL follow REQ-018.

Structure
REQ-031 Package bsu_pkg SHALL hold the mode encodings (MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROL) and the 2-bit mode typedef.
REQ-032 Sub-module bsu_shift_core SHALL be purely combinational. It takes data, shamt and mode, and produces result and carry as a log2(DATA_W)-level mux tree.
REQ-033 The top level SHALL contain only the two stage registers and the handshake logic; no latches; one clock domain.

Verification (DATA_W = 8)
REQ-034 Input 0x1B, LSL by 3 -> out_data 0xD8, carry 0, zero 0, out_valid two edges after accept.
REQ-035 Input 0xB1, ASR by 3 -> 0xF6, carry 0. Input 0x81, LSR by 1 -> 0x40, carry 1.
REQ-036 Input 0x81, ROL by 1 -> 0x03, carry 1. Input 0x80, LSL by 1 -> 0x00, carry 1, zero 1.
REQ-037 Four back-to-back requests with out_ready = 0 -> in_ready drops after two accepts. Raising out_ready then releases results in order with no loss.
REQ-038 Assert rst with both stages full -> out_valid = 0 at the next edge; a new request then completes with latency 2.
REQ-039 Sweep every mode with shamt 0..7 against a reference model; shamt = 0 passes data through with carry 0.
